beh_reset_seq: RTL and testbench
================================

BEH_RESET_SEQ -- requirements
Module: beh_reset_seq

Interface
REQ-001 SHALL have parameter RESETS, default 1: count of reset group bits.
REQ-002 SHALL have parameters STARTS, STEPS, DELAYS, CAPTURES, CUTSCANS, PASSTHRUS and INJECTS, each default 0: counts of the remaining group bits.
REQ-003 SHALL have parameter RESET_CYCLES, default 10: number of reset-phase cycles, legal range 1 or more.
REQ-004 SHALL have parameter CAPTURE_CYCLES, default 10: number of pre-capture-phase cycles, legal range 1 or more.
REQ-005 SHALL have parameter START_CYCLES, default 10: number of capture-to-start cycles, legal range 1 or more.
REQ-006 SHALL define N as the sum of all group counts, minimum 1; group bit ranges SHALL be packed in the order RESET, START, STEP, DELAY, CAPTURE, CUTSCAN, PASSTHRU, INJECT, starting at bit 0.
REQ-007 clk, input, 1 bit: the single clock; all logic is clocked on its rising edge.
REQ-008 reset_n, input, 1 bit: synchronous, active-low reset.
REQ-009 restart, input, 1 bit: single-cycle request to re-run the whole sequence.
REQ-010 dly, input, 1 bit: value to drive on the DELAY group.
REQ-011 step_req, input, 1 bit: single-step request (used only when the macro in REQ-029 is defined).
REQ-012 seq_n, output, N bits: registered group enables.
REQ-013 busy, output, 1 bit: high while the sequence is not in RUN.
REQ-014 done, output, 1 bit: single-cycle pulse on entry to RUN.

Function
REQ-015 SHALL implement a four-state FSM: RST, PRECAP, CAP, RUN.
REQ-016 In RST: PASSTHRU bits SHALL be 1, DELAY bits SHALL equal a dly value sampled every cycle, and all other bits SHALL be 0; after RESET_CYCLES cycles the FSM SHALL go to PRECAP if STARTS+STEPS+CAPTURES>0, otherwise to RUN.
REQ-017 In PRECAP: RESET bits SHALL be 1 in addition to the RST outputs; after CAPTURE_CYCLES cycles the FSM SHALL go to CAP if CAPTURES>0, otherwise to RUN.
REQ-018 In CAP: CAPTURE bits SHALL also be 1; after START_CYCLES cycles the FSM SHALL go to RUN if STARTS+STEPS>0, otherwise to RUN immediately after 1 cycle.
REQ-019 In RUN: START and STEP bits SHALL also be 1; DELAY bits SHALL hold the last dly value sampled in RST.
REQ-020 The duration counter SHALL be $clog2(max duration + 1) bits wide, SHALL clear on every state entry, and SHALL never wrap.
REQ-021 CUTSCAN and INJECT bits SHALL be 0 in every state.
REQ-022 seq_n SHALL reflect the current state one clock after each transition, giving one cycle of registered latency.
REQ-023 restart in any state SHALL force RST with the counter cleared on the next edge; restart takes priority over any pending transition.
REQ-024 busy SHALL be the inverse of the RUN state; done SHALL pulse for exactly one cycle on the cycle RUN is first presented.

Reset
REQ-025 While reset_n is low at a clock edge, the state SHALL be RST, the counter 0, done 0 and busy 1.
REQ-026 While reset_n is low at a clock edge, seq_n SHALL be 0 except PASSTHRU bits, which SHALL be 1.
REQ-027 Deasserting reset_n SHALL start the RST count on the first edge at which reset_n is high.
REQ-028 Asserting reset_n mid-sequence SHALL behave the same as restart, and SHALL also clear done.

Configuration
REQ-029 With BEH_RESET_SEQ_STEP_EN defined, STEP bits in RUN SHALL be 0 except for a one-cycle 1 on the cycle after each step_req high, and step_req SHALL be ignored outside RUN.
REQ-030 Without BEH_RESET_SEQ_STEP_EN, STEP bits SHALL behave exactly as START bits, step_req SHALL be unused, and no step logic SHALL be synthesised.

Verification
REQ-031 Parameters RESETS=1, STARTS=1, CAPTURES=1, PASSTHRUS=1, RESET/CAPTURE/START_CYCLES=10/10/10; release reset_n at cycle 0 -> RESET bit rises at cycle 10, CAPTURE at 20, START at 30, done pulses at 30, busy falls at 30.
REQ-032 Parameters RESETS=2 only, RESET_CYCLES=5 -> both RESET bits rise at cycle 5, done pulses at 5, and there is no PRECAP phase.
REQ-033 DELAYS=3; dly=1 during RST, then 0 in RUN -> DELAY bits read 3'b111 in RUN and stay there.
REQ-034 restart pulsed at cycle 25 of the sequence in REQ-031 -> all non-PASSTHRU bits read 0 at cycle 26, and the full sequence replays with done at cycle 56.
REQ-035 BEH_RESET_SEQ_STEP_EN defined, STEPS=1, step_req high for 3 separate cycles in RUN -> exactly 3 one-cycle STEP pulses; one step_req in RST -> no pulse.
REQ-036 reset_n low for 1 cycle while in CAP -> outputs return to the reset values of REQ-026 on the next edge, and the sequence restarts.

Source files
------------

// File: rtl/beh_reset_seq.sv
// beh_reset_seq: phased reset/start sequencer.
//
// Drives a packed vector of group enables through four phases:
// RST -> PRECAP -> CAP -> RUN. Each phase adds enables on top of the
// previous ones. Groups are packed from bit 0 in the order
// RESET, START, STEP, DELAY, CAPTURE, CUTSCAN, PASSTHRU, INJECT.
// Phases whose groups are all empty are skipped.
//
// Optional feature macro: BEH_RESET_SEQ_STEP_EN
//   When defined, STEP bits in RUN become one-cycle pulses, one per
//   step_req. When undefined, STEP bits follow START bits, and step_req
//   has no load.
module beh_reset_seq #(
  parameter int RESETS         = 1,
  parameter int STARTS         = 0,
  parameter int STEPS          = 0,
  parameter int DELAYS         = 0,
  parameter int CAPTURES       = 0,
  parameter int CUTSCANS       = 0,
  parameter int PASSTHRUS      = 0,
  parameter int INJECTS        = 0,
  parameter int RESET_CYCLES   = 10,
  parameter int CAPTURE_CYCLES = 10,
  parameter int START_CYCLES   = 10,
  localparam int SUM = RESETS + STARTS + STEPS + DELAYS + CAPTURES +
                       CUTSCANS + PASSTHRUS + INJECTS,
  localparam int N   = (SUM < 1) ? 1 : SUM
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         restart,
  input  logic         dly,
  input  logic         step_req,
  output logic [N-1:0] seq_n,
  output logic         busy,
  output logic         done
);

  // Bit offset of each group inside seq_n.
  localparam int O_RST = 0;
  localparam int O_STA = O_RST + RESETS;
  localparam int O_STP = O_STA + STARTS;
  localparam int O_DLY = O_STP + STEPS;
  localparam int O_CAP = O_DLY + DELAYS;
  localparam int O_CUT = O_CAP + CAPTURES;
  localparam int O_PAS = O_CUT + CUTSCANS;
  localparam int O_INJ = O_PAS + PASSTHRUS;

  // Build a mask covering cnt bits starting at off.
  function automatic logic [N-1:0] grp_mask(input int off, input int cnt);
    logic [N-1:0] m;
    m = '0;
    for (int k = 0; k < N; k++) begin
      if ((k >= off) && (k < off + cnt)) m[k] = 1'b1;
    end
    return m;
  endfunction

  localparam logic [N-1:0] M_RST = grp_mask(O_RST, RESETS);
  localparam logic [N-1:0] M_STA = grp_mask(O_STA, STARTS);
  localparam logic [N-1:0] M_STP = grp_mask(O_STP, STEPS);
  localparam logic [N-1:0] M_DLY = grp_mask(O_DLY, DELAYS);
  localparam logic [N-1:0] M_CAP = grp_mask(O_CAP, CAPTURES);
  localparam logic [N-1:0] M_PAS = grp_mask(O_PAS, PASSTHRUS);
  // CUTSCAN and INJECT groups are held low in every phase; their masks
  // exist only to document where they live.
  localparam logic [N-1:0] M_CUT = grp_mask(O_CUT, CUTSCANS);
  localparam logic [N-1:0] M_INJ = grp_mask(O_INJ, INJECTS);
  localparam logic [N-1:0] M_LOW = M_CUT | M_INJ;

  // Phase skipping: PRECAP exists only if something follows it that
  // needs a held reset; CAP only if there is a capture group.
  localparam bit HAS_PRECAP = (STARTS + STEPS + CAPTURES) > 0;
  localparam bit HAS_CAP    = CAPTURES > 0;
  localparam bit HAS_RUNGRP = (STARTS + STEPS) > 0;

  // Counter sized to the longest phase.
  localparam int MAXD_A = (RESET_CYCLES > CAPTURE_CYCLES) ? RESET_CYCLES : CAPTURE_CYCLES;
  localparam int MAXD   = (MAXD_A > START_CYCLES) ? MAXD_A : START_CYCLES;
  localparam int CNT_W  = $clog2(MAXD + 1);

  // Last count value of each phase; CAP collapses to one cycle when no
  // START/STEP group waits on it.
  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(CAPTURE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CAP_LAST = HAS_RUNGRP ? CNT_W'(START_CYCLES - 1) : '0;

  typedef enum logic [1:0] {
    S_RST    = 2'd0,
    S_PRECAP = 2'd1,
    S_CAP    = 2'd2,
    S_RUN    = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N-1:0]     seq_q, seq_d;
  logic             busy_q;
  logic             done_q;
  logic             dly_hold_q;

  // Saturating increment so the duration counter can never wrap.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  // Phase transitions and duration counting; restart overrides everything.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (restart) begin
      state_d = S_RST;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_RST: begin
          if (cnt_q == RST_LAST) begin
            state_d = HAS_PRECAP ? S_PRECAP : S_RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = sat_inc(cnt_q);
          end
        end
        S_PRECAP: begin
          if (cnt_q == PRE_LAST) begin
            state_d = HAS_CAP ? S_CAP : S_RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = sat_inc(cnt_q);
          end
        end
        S_CAP: begin
          if (cnt_q == CAP_LAST) begin
            state_d = S_RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = sat_inc(cnt_q);
          end
        end
        S_RUN: begin
          cnt_d = '0;
        end
        default: begin
          state_d = S_RST;
          cnt_d   = '0;
        end
      endcase
    end
  end

  logic en_rst;
  logic en_cap;
  logic en_run;
  logic dly_val;
  logic step_on;

  // Phase enables are cumulative: each later phase keeps the earlier ones.
  always_comb begin
    en_rst  = (state_q != S_RST);
    en_cap  = (state_q == S_CAP) || (state_q == S_RUN);
    en_run  = (state_q == S_RUN);
    // DELAY follows dly live until RUN, then freezes on the RST sample.
    dly_val = en_run ? dly_hold_q : dly;
`ifdef BEH_RESET_SEQ_STEP_EN
    step_on = en_run && step_req;
`else
    step_on = en_run;
`endif
  end

`ifndef BEH_RESET_SEQ_STEP_EN
  // Without the step feature the request input has no load.
  logic unused_step_req;
  assign unused_step_req = step_req;
`endif

  // Decode the current phase into the next registered enable vector.
  always_comb begin
    seq_d = M_PAS;
    if (en_rst)  seq_d = seq_d | M_RST;
    if (en_cap)  seq_d = seq_d | M_CAP;
    if (en_run)  seq_d = seq_d | M_STA;
    if (step_on) seq_d = seq_d | M_STP;
    seq_d = seq_d | (M_DLY & {N{dly_val}});
    seq_d = seq_d & ~M_LOW;
  end

  // State, counter and registered outputs; reset_n acts like a restart
  // that also forces the outputs to their quiescent values at once.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_RST;
      cnt_q   <= '0;
      seq_q   <= M_PAS;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      seq_q   <= seq_d;
      busy_q  <= (state_q != S_RUN);
      done_q  <= (state_q == S_RUN) && busy_q;
    end
  end

  // Track dly while in RST so RUN can hold the last value seen there.
  always_ff @(posedge clk) begin
    if (reset_n && (state_q == S_RST)) begin
      dly_hold_q <= dly;
    end
  end

  assign seq_n = seq_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_beh_reset_seq.sv
// Bench for beh_reset_seq: four parameter sets share one stimulus stream;
// each is checked every cycle against a timeline model, plus directed
// timing checks for the documented scenarios.
module tb_beh_reset_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n, restart, dly, step_req;
  logic [9:0] seq_a;
  logic [1:0] seq_b;
  logic [4:0] seq_c;
  logic [3:0] seq_d;
  logic [3:0] busy, done;
  logic [31:0] seq_w [4];

  assign seq_w[0] = 32'(seq_a);
  assign seq_w[1] = 32'(seq_b);
  assign seq_w[2] = 32'(seq_c);
  assign seq_w[3] = 32'(seq_d);

  // A: every group present. Bits: RESET0 START1 STEP2 DELAY5:3 CAPTURE6 CUT7 PASS8 INJ9
  beh_reset_seq #(.RESETS(1), .STARTS(1), .STEPS(1), .DELAYS(3), .CAPTURES(1),
                  .CUTSCANS(1), .PASSTHRUS(1), .INJECTS(1),
                  .RESET_CYCLES(10), .CAPTURE_CYCLES(10), .START_CYCLES(10))
    u_a (.clk(clk), .reset_n(reset_n), .restart(restart), .dly(dly),
         .step_req(step_req), .seq_n(seq_a), .busy(busy[0]), .done(done[0]));

  // B: two RESET bits only, no PRECAP/CAP.
  beh_reset_seq #(.RESETS(2), .RESET_CYCLES(5))
    u_b (.clk(clk), .reset_n(reset_n), .restart(restart), .dly(dly),
         .step_req(step_req), .seq_n(seq_b), .busy(busy[1]), .done(done[1]));

  // C: PRECAP but no CAP. Bits: RESET0 START1 DELAY2 PASS4:3
  beh_reset_seq #(.RESETS(1), .STARTS(1), .DELAYS(1), .PASSTHRUS(2),
                  .RESET_CYCLES(3), .CAPTURE_CYCLES(4), .START_CYCLES(7))
    u_c (.clk(clk), .reset_n(reset_n), .restart(restart), .dly(dly),
         .step_req(step_req), .seq_n(seq_c), .busy(busy[2]), .done(done[2]));

  // D: CAP with no START/STEP, so CAP lasts one cycle. Bits: RESET0 CAPTURE2:1 INJ3
  beh_reset_seq #(.RESETS(1), .CAPTURES(2), .INJECTS(1),
                  .RESET_CYCLES(2), .CAPTURE_CYCLES(3), .START_CYCLES(6))
    u_d (.clk(clk), .reset_n(reset_n), .restart(restart), .dly(dly),
         .step_req(step_req), .seq_n(seq_d), .busy(busy[3]), .done(done[3]));

  typedef struct {
    int r, sa, st, d, c, cu, p, i, rc, cc, sc;
  } cfg_t;

  cfg_t cfg [4];
  int   age [4];
  logic pbusy [4];
  logic hold [4];

  int total = 0;
  int bad   = 0;
  int cyc   = -1;

  function automatic logic [31:0] gmask(input int off, input int cnt);
    logic [31:0] m;
    m = '0;
    for (int k = 0; k < 32; k++) if (k >= off && k < off + cnt) m[k] = 1'b1;
    return m;
  endfunction

  // Phase from elapsed edges since sequence start: 0 RST,1 PRECAP,2 CAP,3 RUN.
  function automatic int phase_of(input cfg_t c, input int a);
    int t1, t2, t3;
    t1 = c.rc;
    t2 = t1 + (((c.sa + c.st + c.c) > 0) ? c.cc : 0);
    t3 = t2 + ((c.c > 0) ? (((c.sa + c.st) > 0) ? c.sc : 1) : 0);
    if (a < t1) return 0;
    if (a < t2) return 1;
    if (a < t3) return 2;
    return 3;
  endfunction

  function automatic logic [31:0] pas_mask(input cfg_t c);
    return gmask(c.r + c.sa + c.st + c.d + c.c + c.cu, c.p);
  endfunction

  function automatic logic [31:0] exp_seq(input cfg_t c, input int ph, input logic dn,
                                          input logic dh, input logic sq);
    logic [31:0] v;
    int o_sa, o_st, o_d, o_c;
    logic stp, dv;
    o_sa = c.r; o_st = o_sa + c.sa; o_d = o_st + c.st; o_c = o_d + c.d;
    v = pas_mask(c);
    if (ph >= 1) v = v | gmask(0, c.r);
    if (ph >= 2) v = v | gmask(o_c, c.c);
    if (ph == 3) v = v | gmask(o_sa, c.sa);
`ifdef BEH_RESET_SEQ_STEP_EN
    stp = (ph == 3) && sq;
`else
    stp = (ph == 3);
`endif
    if (stp) v = v | gmask(o_st, c.st);
    dv = (ph == 3) ? dh : dn;
    if (dv) v = v | gmask(o_d, c.d);
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: predict from the inputs seen at the edge, check just after.
  task automatic cycle();
    logic [31:0] e_seq [4];
    logic e_busy [4];
    logic e_done [4];
    int ph;
    @(posedge clk);
    if (!reset_n) cyc = -1; else cyc++;
    for (int i = 0; i < 4; i++) begin
      if (!reset_n) begin
        e_seq[i] = pas_mask(cfg[i]); e_busy[i] = 1'b1; e_done[i] = 1'b0;
        age[i] = 0; pbusy[i] = 1'b1;
      end else begin
        ph = phase_of(cfg[i], age[i]);
        e_seq[i] = exp_seq(cfg[i], ph, dly, hold[i], step_req);
        if (ph == 0) hold[i] = dly;
        e_busy[i] = (ph != 3);
        e_done[i] = (ph == 3) && pbusy[i];
        pbusy[i]  = e_busy[i];
        if (restart) age[i] = 0;
        else if (age[i] < 1000000) age[i]++;
      end
    end
    #1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("seq%0d@%0d", i, cyc), seq_w[i], e_seq[i]);
      chk($sformatf("busy%0d@%0d", i, cyc), 32'(busy[i]), 32'(e_busy[i]));
      chk($sformatf("done%0d@%0d", i, cyc), 32'(done[i]), 32'(e_done[i]));
    end
  endtask

  initial begin
    int r_rst, r_cap, r_sta, r_done, r_busy, rb_rst, rb_done, d2, early_done;
`ifdef BEH_RESET_SEQ_STEP_EN
    int pulses;
`endif
    cfg[0] = '{r:1, sa:1, st:1, d:3, c:1, cu:1, p:1, i:1, rc:10, cc:10, sc:10};
    cfg[1] = '{r:2, sa:0, st:0, d:0, c:0, cu:0, p:0, i:0, rc:5,  cc:10, sc:10};
    cfg[2] = '{r:1, sa:1, st:0, d:1, c:0, cu:0, p:2, i:0, rc:3,  cc:4,  sc:7};
    cfg[3] = '{r:1, sa:0, st:0, d:0, c:2, cu:0, p:0, i:1, rc:2,  cc:3,  sc:6};
    for (int i = 0; i < 4; i++) begin age[i] = 0; pbusy[i] = 1'b1; hold[i] = 1'b0; end

    reset_n = 1'b0; restart = 1'b0; dly = 1'b0; step_req = 1'b0;

    // Reset state.
    repeat (3) cycle();
    chk("rst_seq_a", 32'(seq_a), 32'h100);
    chk("rst_seq_b", 32'(seq_b), 32'h0);
    chk("rst_busy", 32'(busy), 32'hf);
    chk("rst_done", 32'(done), 32'h0);

    // Full sequence from release; dly=1 through RST, 0 once running.
    r_rst = -1; r_cap = -1; r_sta = -1; r_done = -1; r_busy = -1; rb_rst = -1; rb_done = -1;
    reset_n = 1'b1; dly = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if (k == 30) dly = 1'b0;
      cycle();
      if (seq_a[0] && r_rst < 0) r_rst = cyc;
      if (seq_a[6] && r_cap < 0) r_cap = cyc;
      if (seq_a[1] && r_sta < 0) r_sta = cyc;
      if (done[0] && r_done < 0) r_done = cyc;
      if (!busy[0] && r_busy < 0) r_busy = cyc;
      if (seq_b == 2'b11 && rb_rst < 0) rb_rst = cyc;
      if (done[1] && rb_done < 0) rb_done = cyc;
      if (cyc == 35) chk("dly_hold35", 32'(seq_a[5:3]), 32'h7);
    end
    chk("rise_reset", r_rst, 10);
    chk("rise_capture", r_cap, 20);
    chk("rise_start", r_sta, 30);
    chk("done_at", r_done, 30);
    chk("busy_fall", r_busy, 30);
    chk("b_reset_rise", rb_rst, 5);
    chk("b_done_at", rb_done, 5);
    chk("dly_hold39", 32'(seq_a[5:3]), 32'h7);

    // Restart at cycle 25 replays the sequence.
    reset_n = 1'b0; dly = 1'b0;
    cycle();
    reset_n = 1'b1;
    d2 = -1; early_done = 0;
    for (int k = 0; k < 61; k++) begin
      restart = (k == 25);
      cycle();
      if (cyc == 26) chk("restart_clear", 32'(seq_a & ~10'h100), 32'h0);
      if (done[0] && cyc > 26 && d2 < 0) d2 = cyc;
      if (done[0] && cyc <= 26) early_done++;
    end
    restart = 1'b0;
    chk("replay_done", d2, 56);
    chk("no_early_done", early_done, 0);

    // One-cycle reset_n pulse while in CAP.
    restart = 1'b1;
    cycle();
    restart = 1'b0;
    for (int k = 0; k < 24; k++) cycle();
    reset_n = 1'b0;
    cycle();
    chk("cap_rst_seq", 32'(seq_a), 32'h100);
    chk("cap_rst_busy", 32'(busy[0]), 32'h1);
    reset_n = 1'b1;
    d2 = -1;
    for (int k = 0; k < 31; k++) begin
      cycle();
      if (done[0] && d2 < 0) d2 = cyc;
    end
    chk("cap_rst_redone", d2, 30);

`ifdef BEH_RESET_SEQ_STEP_EN
    // Three step requests in RUN give three pulses.
    pulses = 0;
    for (int k = 0; k < 12; k++) begin
      step_req = (k == 1 || k == 5 || k == 9);
      cycle();
      pulses += int'(seq_a[2]);
    end
    step_req = 1'b0;
    chk("step_pulses_run", pulses, 3);
    // A request in RST is ignored.
    restart = 1'b1;
    cycle();
    restart = 1'b0;
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      step_req = (k == 2);
      cycle();
      pulses += int'(seq_a[2]);
    end
    step_req = 1'b0;
    chk("step_pulses_rst", pulses, 0);
`endif

    // Random traffic against the timeline model.
    for (int k = 0; k < 2000; k++) begin
      reset_n  = ($urandom_range(0, 63) != 0);
      restart  = ($urandom_range(0, 39) == 0);
      dly      = 1'($urandom_range(0, 1));
      step_req = ($urandom_range(0, 3) == 0);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
